// File: rtl/pico_pkg.sv
// ============================================================================
// Module   : pico_pkg
// Brief    : Shared widths, store-buffer entry type and dmem port arbitration
//            encoding for the dmem store buffer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package pico_pkg;

   localparam int D_WIDTH = 8;
   localparam int A_WIDTH = 8;

   typedef struct packed {
      logic [A_WIDTH-1:0] addr;
      logic [D_WIDTH-1:0] data;
   } stbuf_entry_t;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_LOAD  = 2'd1,
      ARB_DRAIN = 2'd2
   } arb_e;

endpackage

`default_nettype wire

// File: rtl/stbuf_match.sv
// ============================================================================
// Module   : stbuf_match
// Brief    : Parallel load-address compare across the occupied store-buffer
//            entries; reports a hit and the index of the youngest match.
// Revision : 1.0
// ============================================================================
`default_nettype none

module stbuf_match #(
   parameter int  A_WIDTH = 8,
   parameter int  DEPTH   = 4,
   localparam int PW      = $clog2(DEPTH),
   localparam int CW      = PW + 1
) (
   input  logic [DEPTH-1:0][A_WIDTH-1:0] addr_i,
   input  logic [PW-1:0]                 head_i,
   input  logic [CW-1:0]                 count_i,
   input  logic [A_WIDTH-1:0]            ld_addr_i,
   output logic                          hit_o,
   output logic [PW-1:0]                 hit_idx_o
);

   logic [PW-1:0] slot;

   // Walk oldest to youngest so the last match seen is the one nearest tail.
   always_comb begin
      hit_o     = 1'b0;
      hit_idx_o = '0;
      slot      = '0;
      for (int k = 0; k < DEPTH; k++) begin
         slot = head_i + PW'(k);
         if ((CW'(k) < count_i) && (addr_i[slot] == ld_addr_i)) begin
            hit_o     = 1'b1;
            hit_idx_o = slot;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/dmem_store_buffer.sv
// ============================================================================
// Module   : dmem_store_buffer
// Brief    : Posted-write FIFO in front of the single-port dmem; drains one
//            store per cycle whenever the port is not taken by a load.
//            Option macro STBUF_FWD_EN enables store-to-load forwarding.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dmem_store_buffer
   import pico_pkg::*;
#(
   parameter int  D_WIDTH = pico_pkg::D_WIDTH,
   parameter int  A_WIDTH = pico_pkg::A_WIDTH,
   parameter int  DEPTH   = 4,
   localparam int PW      = $clog2(DEPTH),
   localparam int CW      = PW + 1
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               st_valid_i,
   output logic               st_ready_o,
   input  logic [A_WIDTH-1:0] st_addr_i,
   input  logic [D_WIDTH-1:0] st_data_i,
   input  logic               ld_valid_i,
   output logic               ld_ready_o,
   input  logic [A_WIDTH-1:0] ld_addr_i,
   output logic [D_WIDTH-1:0] ld_data_o,
   output logic [CW-1:0]      buf_count_o,
   output logic               buf_empty_o,
   output logic [A_WIDTH-1:0] dmem_alu_result_o,
   output logic [D_WIDTH-1:0] dmem_in_o,
   output logic               dmem_write_en_o,
   input  logic [D_WIDTH-1:0] dmem_out_i
);

   logic [DEPTH-1:0][A_WIDTH-1:0] addr_q;
   logic [D_WIDTH-1:0]            data_q [DEPTH];
   logic [PW-1:0]                 head_q, head_d;
   logic [PW-1:0]                 tail_q, tail_d;
   logic [CW-1:0]                 count_q, count_d;

   logic          full, hit, fwd_sel, push, pop;
   logic [PW-1:0] hit_idx;
   arb_e          arb;

   stbuf_match #(
      .A_WIDTH (A_WIDTH),
      .DEPTH   (DEPTH)
   ) u_match (
      .addr_i    (addr_q),
      .head_i    (head_q),
      .count_i   (count_q),
      .ld_addr_i (ld_addr_i),
      .hit_o     (hit),
      .hit_idx_o (hit_idx)
   );

   always_comb begin
      full = (count_q == CW'(DEPTH));
`ifdef STBUF_FWD_EN
      fwd_sel    = hit;
      ld_ready_o = ld_valid_i & ~full;
`else
      // A load hitting a pending store waits until that store has drained.
      fwd_sel    = 1'b0;
      ld_ready_o = ld_valid_i & ~full & ~hit;
`endif
      ld_data_o = fwd_sel ? data_q[hit_idx] : dmem_out_i;

      arb = ARB_IDLE;
      if (ld_ready_o)
         arb = ARB_LOAD;
      else if (count_q != '0)
         arb = ARB_DRAIN;

      pop  = (arb == ARB_DRAIN);
      push = st_valid_i & ~full;

      st_ready_o        = ~full;
      buf_count_o       = count_q;
      buf_empty_o       = (count_q == '0);
      dmem_alu_result_o = pop ? addr_q[head_q] : ld_addr_i;
      dmem_in_o         = data_q[head_q];
      dmem_write_en_o   = pop;

      head_d  = head_q + PW'(pop);
      tail_d  = tail_q + PW'(push);
      count_d = count_q + CW'(push) - CW'(pop);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         addr_q  <= '0;
         for (int i = 0; i < DEPTH; i++)
            data_q[i] <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         if (push) begin
            addr_q[tail_q] <= st_addr_i;
            data_q[tail_q] <= st_data_i;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_dmem_store_buffer.sv
// ============================================================================
// Module   : tb_dmem_store_buffer
// Brief    : Self-checking bench for dmem_store_buffer with a dmem model and a
//            queue-based reference of the buffer (STBUF_FWD_EN aware).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dmem_store_buffer;
   import pico_pkg::*;

   localparam int TB_DEPTH = 4;
`ifdef STBUF_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic       clk, rst_ni;
   logic       st_valid, st_ready, ld_valid, ld_ready;
   logic [7:0] st_addr, st_data, ld_addr, ld_data;
   logic [2:0] buf_count;
   logic       buf_empty, dmem_we;
   logic [7:0] dmem_addr, dmem_in, dmem_out;

   logic [7:0] dmem [256];
   logic [7:0] mm   [256];
   stbuf_entry_t q[$];

   int n_checks = 0;
   int n_errors = 0;

   dmem_store_buffer #(.D_WIDTH(8), .A_WIDTH(8), .DEPTH(TB_DEPTH)) dut (
      .clk_i             (clk),
      .rst_ni            (rst_ni),
      .st_valid_i        (st_valid),
      .st_ready_o        (st_ready),
      .st_addr_i         (st_addr),
      .st_data_i         (st_data),
      .ld_valid_i        (ld_valid),
      .ld_ready_o        (ld_ready),
      .ld_addr_i         (ld_addr),
      .ld_data_o         (ld_data),
      .buf_count_o       (buf_count),
      .buf_empty_o       (buf_empty),
      .dmem_alu_result_o (dmem_addr),
      .dmem_in_o         (dmem_in),
      .dmem_write_en_o   (dmem_we),
      .dmem_out_i        (dmem_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural dmem: combinational read, posedge write, cleared by reset.
   assign dmem_out = dmem[dmem_addr];
   always @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < 256; i++) dmem[i] <= 8'h00;
      end else if (dmem_we) begin
         dmem[dmem_addr] <= dmem_in;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: outputs derived from the queue of pending stores and the
   // architectural memory image, checked every cycle.
   always @(negedge clk) begin
      if (!rst_ni) begin
         q.delete();
         for (int i = 0; i < 256; i++) mm[i] = 8'h00;
         chk("rst_count", 32'(buf_count), 0);
         chk("rst_we", 32'(dmem_we), 0);
         chk("rst_st_ready", 32'(st_ready), 1);
         chk("rst_empty", 32'(buf_empty), 1);
      end else begin
         automatic int         sz = q.size();
         automatic bit         full = (sz == TB_DEPTH);
         automatic bit         hit = 1'b0;
         automatic logic [7:0] hd = 8'h00;
         automatic bit         exp_ldr;
         foreach (q[i]) if (q[i].addr == ld_addr) begin hit = 1'b1; hd = q[i].data; end
         exp_ldr = ld_valid && !full && !(hit && !FWD);
         chk("m_count", 32'(buf_count), 32'(sz));
         chk("m_empty", 32'(buf_empty), 32'(sz == 0));
         chk("m_st_ready", 32'(st_ready), 32'(!full));
         chk("m_ld_ready", 32'(ld_ready), 32'(exp_ldr));
         if (exp_ldr) begin
            chk("m_ld_data", 32'(ld_data), 32'(hit ? hd : mm[ld_addr]));
            chk("m_we_load", 32'(dmem_we), 0);
            chk("m_addr_load", 32'(dmem_addr), 32'(ld_addr));
         end else if (sz != 0) begin
            chk("m_we_drain", 32'(dmem_we), 1);
            chk("m_addr_drain", 32'(dmem_addr), 32'(q[0].addr));
            chk("m_din_drain", 32'(dmem_in), 32'(q[0].data));
            mm[q[0].addr] = q[0].data;
            void'(q.pop_front());
         end else begin
            chk("m_we_idle", 32'(dmem_we), 0);
            chk("m_addr_idle", 32'(dmem_addr), 32'(ld_addr));
         end
         if (st_valid && !full) q.push_back('{addr: st_addr, data: st_data});
      end
   end

   task automatic set_in(input bit sv, input logic [7:0] sa, input logic [7:0] sd,
                         input bit lv, input logic [7:0] la);
      st_valid = sv; st_addr = sa; st_data = sd; ld_valid = lv; ld_addr = la;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_empty();
      set_in(0, 8'h00, 8'h00, 0, 8'h00);
      for (int n = 0; n < 16 && !buf_empty; n++) tick();
      chk("drain_timeout", 32'(buf_empty), 1);
   endtask

   initial begin
      rst_ni = 1'b0;
      set_in(0, 8'h00, 8'h00, 0, 8'h00);
      repeat (2) @(posedge clk);
      @(negedge clk); #1 rst_ni = 1'b1;
      tick();
      chk("reset_count", 32'(buf_count), 0);
      chk("reset_st_ready", 32'(st_ready), 1);
      chk("reset_empty", 32'(buf_empty), 1);

      // Two posted stores, no loads.
      set_in(1, 8'h10, 8'hAA, 0, 8'h00); tick();
      set_in(1, 8'h11, 8'hBB, 0, 8'h00); tick();
      set_in(0, 8'h00, 8'h00, 0, 8'h00); tick();
      chk("t1_mem10", 32'(dmem[8'h10]), 32'hAA);
      chk("t1_mem11", 32'(dmem[8'h11]), 32'hBB);
      chk("t1_empty", 32'(buf_empty), 1);

      // Fill behind a load stream; full forces a drain.
      for (int i = 0; i < 4; i++) begin
         set_in(1, 8'(8'h30 + i), 8'(8'h50 + i), 1, 8'h40);
         tick();
      end
      set_in(0, 8'h00, 8'h00, 1, 8'h40);
      #1;
      chk("t2_count_full", 32'(buf_count), 4);
      chk("t2_st_ready", 32'(st_ready), 0);
      chk("t2_ld_ready_full", 32'(ld_ready), 0);
      chk("t2_drain_we", 32'(dmem_we), 1);
      tick();
      chk("t2_count_after", 32'(buf_count), 3);
      chk("t2_ld_resume", 32'(ld_ready), 1);
      wait_empty();

      // Same-address stores then a load of that address.
      set_in(1, 8'h20, 8'h11, 0, 8'h00); tick();
      set_in(1, 8'h20, 8'h22, 1, 8'h50); tick();
      set_in(0, 8'h00, 8'h00, 1, 8'h20);
      #1;
      if (FWD) begin
         chk("t3_fwd_ready", 32'(ld_ready), 1);
         chk("t3_fwd_data", 32'(ld_data), 32'h22);
      end else begin
         chk("t3_blocked", 32'(ld_ready), 0);
         for (int n = 0; n < 8 && !ld_ready; n++) tick();
         chk("t3_ready_timeout", 32'(ld_ready), 1);
         chk("t3_data", 32'(ld_data), 32'h22);
         chk("t3_count", 32'(buf_count), 0);
      end
      wait_empty();

      // Store and load to the same address on an empty buffer.
      set_in(1, 8'h60, 8'h5A, 0, 8'h00); tick();
      wait_empty();
      set_in(1, 8'h60, 8'h77, 1, 8'h60);
      #1;
      chk("t4_ld_ready", 32'(ld_ready), 1);
      chk("t4_old_data", 32'(ld_data), 32'h5A);
      tick();
      set_in(0, 8'h00, 8'h00, 0, 8'h00);
      #1;
      chk("t4_drain_we", 32'(dmem_we), 1);
      chk("t4_drain_addr", 32'(dmem_addr), 32'h60);
      chk("t4_drain_data", 32'(dmem_in), 32'h77);
      tick();
      chk("t4_mem", 32'(dmem[8'h60]), 32'h77);

      // Reset with pending entries discards them.
      for (int i = 0; i < 3; i++) begin
         set_in(1, 8'(8'h70 + i), 8'(8'hC1 + i), 1, 8'h90);
         tick();
      end
      set_in(0, 8'h00, 8'h00, 0, 8'h00);
      #1;
      chk("t5_count_pre", 32'(buf_count), 3);
      rst_ni = 1'b0;
      #1;
      chk("t5_count_rst", 32'(buf_count), 0);
      chk("t5_we_rst", 32'(dmem_we), 0);
      tick(); tick();
      @(negedge clk); #1 rst_ni = 1'b1;
      repeat (4) tick();
      chk("t5_mem70", 32'(dmem[8'h70]), 0);
      chk("t5_mem72", 32'(dmem[8'h72]), 0);

      // Pointer wrap with interleaved stores and drains.
      for (int i = 0; i < 10; i++) begin
         set_in(1, 8'(8'hA0 + i), 8'(i * 7 + 3), 0, 8'h00); tick();
         set_in(0, 8'h00, 8'h00, 0, 8'h00); tick();
      end
      wait_empty();
      for (int i = 0; i < 10; i++)
         chk("t6_wrap_mem", 32'(dmem[8'(8'hA0 + i)]), 32'(i * 7 + 3));

      // Randomised traffic over a small address window to provoke hits.
      for (int n = 0; n < 400; n++) begin
         set_in(1'($urandom_range(0, 99) < 60), 8'(8'h80 + $urandom_range(0, 5)),
                8'($urandom), 1'($urandom_range(0, 99) < 50), 8'(8'h80 + $urandom_range(0, 5)));
         tick();
      end
      wait_empty();
      begin
         automatic int bad = 0;
         for (int i = 0; i < 256; i++) if (dmem[i] !== mm[i]) bad++;
         chk("final_mem_image", 32'(bad), 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule

`default_nettype wire
